// File: rtl/toll_datapath.sv
// Toll-lane datapath: transit timer, fee/balance settlement, lane occupancy and barrier state.
// Optional TOLL_LOG_EN adds txn_count/revenue transaction logging.
module toll_datapath #(
  parameter int unsigned TIMER_W     = 16,
  parameter int unsigned BAL_W       = 16,
  parameter int unsigned BASE_FEE    = 20,
  parameter int unsigned SPEED_FINE  = 50,
  parameter int unsigned MIN_TRANSIT = 100
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               init,
  input  logic               count,
  input  logic               cal,
  input  logic               up,
  input  logic               down,
  input  logic               en,
  input  logic               dis,
  input  logic               card_present,
  input  logic [BAL_W-1:0]   card_balance,
  output logic               valid_Epass,
  output logic [1:0]         num_veh,
  output logic               done,
  output logic [BAL_W-1:0]   fee,
  output logic [TIMER_W-1:0] elapsed,
  output logic [BAL_W-1:0]   new_balance,
  output logic               wr_balance,
  output logic               barrier_open
`ifdef TOLL_LOG_EN
  ,
  output logic [15:0]        txn_count,
  output logic [31:0]        revenue
`endif
);

  // Fast-transit fee is summed one bit wider and clamped so it never wraps below the base fee.
  localparam logic [BAL_W:0]   FEE_SUM  = (BAL_W+1)'(BASE_FEE) + (BAL_W+1)'(SPEED_FINE);
  localparam logic [BAL_W-1:0] FEE_BASE = BAL_W'(BASE_FEE);
  localparam logic [BAL_W-1:0] FEE_FAST = FEE_SUM[BAL_W] ? {BAL_W{1'b1}} : FEE_SUM[BAL_W-1:0];

  logic [TIMER_W-1:0] elapsed_q, elapsed_d;
  logic [1:0]         num_veh_q, num_veh_d;
  logic               done_q, done_d;
  logic [BAL_W-1:0]   new_balance_q, new_balance_d;
  logic               wr_balance_q, wr_balance_d;
  logic               barrier_open_q, barrier_open_d;
`ifdef TOLL_LOG_EN
  logic [15:0]        txn_count_q, txn_count_d;
  logic [31:0]        revenue_q, revenue_d;
`endif

  assign fee         = (32'(elapsed_q) < MIN_TRANSIT) ? FEE_FAST : FEE_BASE;
  assign valid_Epass = card_present & (card_balance >= fee);

  // Next-state for timer, settlement, occupancy and barrier paths.
  always_comb begin
    elapsed_d      = elapsed_q;
    num_veh_d      = num_veh_q;
    done_d         = 1'b0;
    new_balance_d  = new_balance_q;
    wr_balance_d   = 1'b0;
    barrier_open_d = barrier_open_q;
`ifdef TOLL_LOG_EN
    txn_count_d    = txn_count_q;
    revenue_d      = revenue_q;
`endif

    if (init) begin
      elapsed_d = '0;
    end else if (count && (elapsed_q != {TIMER_W{1'b1}})) begin
      elapsed_d = elapsed_q + TIMER_W'(1);
    end

    if (cal) begin
      done_d        = 1'b1;
      wr_balance_d  = valid_Epass;
      new_balance_d = valid_Epass ? (card_balance - fee) : card_balance;
`ifdef TOLL_LOG_EN
      if (valid_Epass) begin
        txn_count_d = txn_count_q + 16'd1;
        revenue_d   = revenue_q + 32'(fee);
      end
`endif
    end

    if (up && !down && (num_veh_q != 2'd3)) begin
      num_veh_d = num_veh_q + 2'd1;
    end else if (down && !up && (num_veh_q != 2'd0)) begin
      num_veh_d = num_veh_q - 2'd1;
    end

    if (dis) begin
      barrier_open_d = 1'b0;
    end else if (en) begin
      barrier_open_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      elapsed_q      <= '0;
      num_veh_q      <= '0;
      done_q         <= 1'b0;
      new_balance_q  <= '0;
      wr_balance_q   <= 1'b0;
      barrier_open_q <= 1'b0;
`ifdef TOLL_LOG_EN
      txn_count_q    <= '0;
      revenue_q      <= '0;
`endif
    end else begin
      elapsed_q      <= elapsed_d;
      num_veh_q      <= num_veh_d;
      done_q         <= done_d;
      new_balance_q  <= new_balance_d;
      wr_balance_q   <= wr_balance_d;
      barrier_open_q <= barrier_open_d;
`ifdef TOLL_LOG_EN
      txn_count_q    <= txn_count_d;
      revenue_q      <= revenue_d;
`endif
    end
  end

  assign elapsed      = elapsed_q;
  assign num_veh      = num_veh_q;
  assign done         = done_q;
  assign new_balance  = new_balance_q;
  assign wr_balance   = wr_balance_q;
  assign barrier_open = barrier_open_q;
`ifdef TOLL_LOG_EN
  assign txn_count    = txn_count_q;
  assign revenue      = revenue_q;
`endif

endmodule

// File: tb/tb_toll_datapath.sv
// Scoreboard bench for toll_datapath: random and directed strobes against a cycle-level reference model.
module tb_toll_datapath;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        init, count, cal, up, down, en, dis, card_present;
  logic [15:0] card_balance;
  logic        valid_Epass, done, wr_balance, barrier_open;
  logic [1:0]  num_veh;
  logic [15:0] fee, elapsed, new_balance;
`ifdef TOLL_LOG_EN
  logic [15:0] txn_count;
  logic [31:0] revenue;
  logic [15:0] t_txn_count;
  logic [31:0] t_revenue;
`endif

  // Small instance: 4-bit timer saturation and 6-bit fee clamp.
  logic        t_init, t_count;
  logic [5:0]  t_card_balance;
  logic        t_valid_Epass, t_done, t_wr_balance, t_barrier_open;
  logic [1:0]  t_num_veh;
  logic [5:0]  t_fee, t_new_balance;
  logic [3:0]  t_elapsed;

  toll_datapath dut (
    .clk(clk), .reset_n(reset_n), .init(init), .count(count), .cal(cal),
    .up(up), .down(down), .en(en), .dis(dis), .card_present(card_present),
    .card_balance(card_balance), .valid_Epass(valid_Epass), .num_veh(num_veh),
    .done(done), .fee(fee), .elapsed(elapsed), .new_balance(new_balance),
    .wr_balance(wr_balance), .barrier_open(barrier_open)
`ifdef TOLL_LOG_EN
    , .txn_count(txn_count), .revenue(revenue)
`endif
  );

  toll_datapath #(.TIMER_W(4), .BAL_W(6)) dut_small (
    .clk(clk), .reset_n(reset_n), .init(t_init), .count(t_count), .cal(1'b0),
    .up(1'b0), .down(1'b0), .en(1'b0), .dis(1'b0), .card_present(1'b0),
    .card_balance(t_card_balance), .valid_Epass(t_valid_Epass), .num_veh(t_num_veh),
    .done(t_done), .fee(t_fee), .elapsed(t_elapsed), .new_balance(t_new_balance),
    .wr_balance(t_wr_balance), .barrier_open(t_barrier_open)
`ifdef TOLL_LOG_EN
    , .txn_count(t_txn_count), .revenue(t_revenue)
`endif
  );

  typedef struct {
    int     cyc;
    bit     valid;
    int     nb;
    int     txn;
    longint rev;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;

  // Reference model state
  int     m_el, m_nv, m_bar, m_nb, m_txn;
  longint m_rev;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  function automatic int model_fee(input int el);
    int s;
    if (el >= 100) return 20;
    s = 20 + 50;
    return (s > 65535) ? 65535 : s;
  endfunction

  task automatic model_reset();
    m_el = 0; m_nv = 0; m_bar = 0; m_nb = 0; m_txn = 0; m_rev = 0;
  endtask

  // One clock of stimulus: check registered state, drive, check combinational outputs, advance model.
  task automatic step(input bit i, input bit c, input bit ca, input bit u, input bit d,
                      input bit e, input bit ds, input bit cp, input int bal);
    int   f;
    bit   v;
    exp_t x;
    @(negedge clk);
    chk("elapsed", elapsed, m_el);
    chk("num_veh", num_veh, m_nv);
    chk("barrier_open", barrier_open, m_bar);
    chk("new_balance_hold", new_balance, m_nb);
    init = i; count = c; cal = ca; up = u; down = d; en = e; dis = ds;
    card_present = cp; card_balance = 16'(bal);
    #1;
    f = model_fee(m_el);
    v = cp && (bal >= f);
    chk("fee", fee, f);
    chk("valid_Epass", valid_Epass, v);
    if (ca) begin
      x.cyc = cyc + 1;
      x.valid = v;
      x.nb = v ? bal - f : bal;
      m_nb = x.nb;
      if (v) begin
        m_txn = (m_txn + 1) % 65536;
        m_rev = (m_rev + f) % 64'h1_0000_0000;
      end
      x.txn = m_txn;
      x.rev = m_rev;
      q.push_back(x);
    end
    if (i) m_el = 0;
    else if (c) m_el = (m_el + 1 > 65535) ? 65535 : m_el + 1;
    if (u && !d) m_nv = (m_nv == 3) ? 3 : m_nv + 1;
    else if (d && !u) m_nv = (m_nv == 0) ? 0 : m_nv - 1;
    if (ds) m_bar = 0;
    else if (e) m_bar = 1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Settlement monitor
  always @(negedge clk) begin : monitor
    exp_t e;
    if (reset_n) begin
      if (done) begin
        if (q.size() == 0) begin
          chk("done_unexpected", done, 0);
        end else begin
          e = q.pop_front();
          chk("done_latency", cyc, e.cyc);
          chk("wr_balance", wr_balance, e.valid);
          chk("new_balance_settle", new_balance, e.nb);
`ifdef TOLL_LOG_EN
          chk("txn_count", txn_count, e.txn);
          chk("revenue", revenue, e.rev);
`endif
        end
      end else if (wr_balance) begin
        chk("wr_without_done", wr_balance, 0);
      end
    end
  end

  initial begin
    int r, bal, f;
    reset_n = 1'b0;
    {init, count, cal, up, down, en, dis, card_present} = '0;
    card_balance = '0; t_init = 0; t_count = 0; t_card_balance = '0;
    model_reset();
    #12;
    chk("rst_elapsed", elapsed, 0);
    chk("rst_done", done, 0);
    chk("rst_wr_balance", wr_balance, 0);
    chk("rst_new_balance", new_balance, 0);
    @(negedge clk) reset_n = 1'b1;

    // Mid-transit async reset
    step(1, 0, 0, 0, 0, 1, 0, 0, 0);
    step(0, 1, 0, 1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 38; k++) step(0, 1, 0, 0, 0, 0, 0, 0, 0);
    idle(1);
    chk("pre_reset_elapsed", elapsed, 40);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_elapsed", elapsed, 0);
    chk("async_rst_num_veh", num_veh, 0);
    chk("async_rst_barrier", barrier_open, 0);
    chk("async_rst_done", done | wr_balance, 0);
    model_reset();
    @(negedge clk) reset_n = 1'b1;

    // Slow transit, sufficient balance
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 150; k++) step(0, 1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0, 1, 100);
    chk("fee_slow", fee, 20);
    idle(2);
    chk("balance_debited", new_balance, 80);

    // Fast transit, insufficient balance
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 50; k++) step(0, 1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0, 1, 60);
    chk("fee_fast", fee, 70);
    chk("valid_low_funds", valid_Epass, 0);
    idle(2);
    chk("balance_untouched", new_balance, 60);

    // Exact-balance boundary
    step(0, 0, 1, 0, 0, 0, 0, 1, 70);
    idle(2);

    // Occupancy saturation and simultaneous up/down
    for (int k = 0; k < 4; k++) step(0, 0, 0, 1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) step(0, 0, 0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 1, 0, 0, 0, 0);
    idle(1);
    chk("up_down_hold", num_veh, 1);

    // Barrier priority
    step(0, 0, 0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 1, 0, 0);
    idle(2);
    chk("barrier_dis_wins", barrier_open, 0);

    // Narrow instance: timer saturation, then restart
    @(negedge clk) t_init = 1;
    @(negedge clk) begin t_init = 0; t_count = 1; end
    repeat (20) @(negedge clk);
    t_count = 0;
    #1 chk("small_timer_sat", t_elapsed, 15);
    chk("small_fee_clamp", t_fee, 63);
    t_init = 1;
    @(negedge clk) begin t_init = 0; t_count = 1; end
    @(negedge clk) t_count = 0;
    #1 chk("small_timer_restart", t_elapsed, 1);

    // Random traffic
    for (int k = 0; k < 2500; k++) begin
      f = model_fee(m_el);
      r = $urandom_range(0, 5);
      case (r)
        0: bal = f;
        1: bal = f - 1;
        2: bal = 69;
        3: bal = 20;
        default: bal = $urandom_range(0, 200);
      endcase
      step(($urandom % 200) == 0, ($urandom % 8) != 0, ($urandom % 10) == 0,
           ($urandom % 4) == 0, ($urandom % 4) == 0, ($urandom % 4) == 0,
           ($urandom % 4) == 0, ($urandom % 4) != 0, bal);
    end
    idle(3);
    chk("pending_settlements", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got %0d cycles expected completion", cyc);
    $fatal(1, "timeout");
  end

endmodule
